// File: rtl/bist_result_monitor_pkg.sv
// ---------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the FIFO BIST blocks: default geometry shared with the
// FIFO and ROM, and the result-monitor state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package bist_pkg;

  localparam int DEF_DEPTH  = 16;  // compares expected per run (FIFO depth)
  localparam int DEF_ADDR_W = 4;   // read index width
  localparam int DEF_CNT_W  = 8;   // statistics counter width

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } mon_state_t;

endpackage

// File: rtl/bist_result_monitor_if.sv
// ---------------------------------------------------------------------------
// bist_result_monitor_if
// Bundles the compare stream (start/rd_valid/pass/rd_addr/last) and the BIST
// status returned to the top level.
//   master : compare-stream source, reads status
//   slave  : result monitor, consumes the stream and drives status
// ---------------------------------------------------------------------------
interface bist_result_monitor_if
  import bist_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
);

  // compare stream
  logic              start;
  logic              rd_valid;
  logic              pass;
  logic [ADDR_W-1:0] rd_addr;
  logic              last;

  // status
  logic              busy;
  logic              done;
  logic              fail;
  logic [CNT_W-1:0]  err_cnt;
  logic [CNT_W-1:0]  cmp_cnt;
  logic              first_err_valid;
  logic [ADDR_W-1:0] first_err_addr;

  modport master (
    output start, rd_valid, pass, rd_addr, last,
    input  busy, done, fail, err_cnt, cmp_cnt, first_err_valid, first_err_addr
  );

  modport slave (
    input  start, rd_valid, pass, rd_addr, last,
    output busy, done, fail, err_cnt, cmp_cnt, first_err_valid, first_err_addr
  );

endinterface

// File: rtl/bist_result_monitor_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk : clock          rst : synchronous active-high reset
//   clr : synchronous clear (wins over inc)
//   inc : count enable   q   : current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] Q_MAX = {W{1'b1}};
  localparam logic [W-1:0] Q_ONE = {{(W-1){1'b0}}, 1'b1};

  // count register with clear priority and saturation at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= {W{1'b0}};
    end else if (clr) begin
      q <= {W{1'b0}};
    end else if (inc && (q != Q_MAX)) begin
      q <= q + Q_ONE;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/bist_result_monitor.sv
// ---------------------------------------------------------------------------
// bist_result_monitor
// Watches the FIFO/ROM comparator result on every valid read compare, counts
// compares and mismatches, captures the first failing read address, and at
// end of run reports DONE with a sticky pass/fail verdict.
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset, dominates all inputs
//   bus : slave side of bist_result_monitor_if (compare stream in, status out)
// ---------------------------------------------------------------------------
module bist_result_monitor
  import bist_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic                  clk,
  input logic                  rst,
  bist_result_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]      DEPTH_EXT = 32'(DEPTH);

  mon_state_t       state;
  mon_state_t       state_next;
  logic             sample;
  logic             err_inc;
  logic             fin;
  logic             verdict;
  logic [CNT_W-1:0] cmp_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] cmp_next;
  logic [CNT_W-1:0] err_next;

  // A compare only counts in RUN and never in a START cycle (START wins).
  assign sample  = (state == RUN) && bus.rd_valid && !bus.start;
  assign err_inc = sample && !bus.pass;
  assign fin     = sample && bus.last;

  // next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) state_next = RUN;
        else           state_next = IDLE;
      end
      RUN: begin
        if (bus.start) state_next = RUN;
        else if (fin)  state_next = REPORT;
        else           state_next = RUN;
      end
      REPORT: begin
        if (bus.start) state_next = RUN;
        else           state_next = REPORT;
      end
      default: state_next = IDLE;
    endcase
  end

  // state register with BUSY/DONE registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state    <= state_next;
      bus.busy <= (state_next == RUN);
      bus.done <= (state_next == REPORT);
    end
  end

  sat_counter #(.W(CNT_W)) u_cmp_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.start),
    .inc (sample),
    .q   (cmp_q)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.start),
    .inc (err_inc),
    .q   (err_q)
  );

  assign bus.cmp_cnt = cmp_q;
  assign bus.err_cnt = err_q;

  // Counter values as they will be after the final compare, so the verdict
  // includes the LAST sample itself.
  always_comb begin
    cmp_next = cmp_q;
    err_next = err_q;
    if (cmp_q != CNT_MAX) begin
      cmp_next = cmp_q + CNT_ONE;
    end else begin
      cmp_next = cmp_q;
    end
    if (!bus.pass && (err_q != CNT_MAX)) begin
      err_next = err_q + CNT_ONE;
    end else begin
      err_next = err_q;
    end
  end

  // Short or long runs fail too; compare in 32 bits so a narrow counter
  // cannot alias DEPTH.
  assign verdict = (err_next != {CNT_W{1'b0}}) ||
                   ({{(32-CNT_W){1'b0}}, cmp_next} != DEPTH_EXT);

  // sticky verdict captured on entry to REPORT
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.fail <= 1'b0;
    end else if (bus.start) begin
      bus.fail <= 1'b0;
    end else if (fin) begin
      bus.fail <= verdict;
    end else begin
      bus.fail <= bus.fail;
    end
  end

  // first-mismatch capture, armed once per run
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.first_err_valid <= 1'b0;
      bus.first_err_addr  <= {ADDR_W{1'b0}};
    end else if (bus.start) begin
      bus.first_err_valid <= 1'b0;
      bus.first_err_addr  <= {ADDR_W{1'b0}};
    end else if (err_inc && !bus.first_err_valid) begin
      bus.first_err_valid <= 1'b1;
      bus.first_err_addr  <= bus.rd_addr;
    end else begin
      bus.first_err_valid <= bus.first_err_valid;
      bus.first_err_addr  <= bus.first_err_addr;
    end
  end

endmodule
